mp_alu_seq: RTL

//  Multi-precision sequential ALU: next generation of the two-register 16-bit ALU.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_limb.sv | 62 ++++++
 rtl/mp_alu_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and chain helpers for the multi-precision sequential ALU.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OpNot   = 4'd0,
    OpAdd   = 4'd1,
    OpSub   = 4'd2,
    OpAnd   = 4'd3,
    OpOr    = 4'd4,
    OpShr   = 4'd5,
    OpShl   = 4'd6,
    OpInc   = 4'd7,
    OpXor   = 4'd8,
    OpAdc   = 4'd9,
    OpSbb   = 4'd10,
    OpAsr   = 4'd11,
    OpPass  = 4'd12,
    OpRes13 = 4'd13,
    OpRes14 = 4'd14,
    OpRes15 = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Chain bit fed into the first processed limb.
  function automatic logic chain_init(op_e op, logic b_msb, logic carry_reg);
    case (op)
      OpSub, OpInc: chain_init = 1'b1;
      OpAdc:        chain_init = carry_reg;
      OpSbb:        chain_init = ~carry_reg;
      OpAsr:        chain_init = b_msb;
      default:      chain_init = 1'b0;
    endcase
  endfunction

  // Externally visible carry from the chain bit leaving the last processed limb.
  function automatic logic carry_from_chain(op_e op, logic chain);
    case (op)
      OpAdd, OpAdc, OpInc, OpShl, OpShr, OpAsr: carry_from_chain = chain;
      OpSub, OpSbb:                             carry_from_chain = ~chain;
      default:                                  carry_from_chain = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_limb.sv
// Combinational W-bit ALU slice; the chain bit carries either the adder carry or the shifted bit.
module alu_limb
  import alu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  op_e          op_i,
  input  logic [W-1:0] a_limb_i,
  input  logic [W-1:0] b_limb_i,
  input  logic         chain_i,
  input  logic         is_msb_i,
  output logic [W-1:0] res_limb_o,
  output logic         chain_o,
  output logic         limb_zero_o,
  output logic         ovf_limb_o
);

  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W:0]   sum;

  // INC adds b to a zero operand with the chain preset to 1; SUB/SBB add the inverted b.
  always_comb begin
    x   = (op_i == OpInc) ? '0 : a_limb_i;
    y   = (op_i == OpSub || op_i == OpSbb) ? ~b_limb_i : b_limb_i;
    sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, chain_i};
  end

  always_comb begin
    res_limb_o = '0;
    chain_o    = 1'b0;
    ovf_limb_o = 1'b0;
    case (op_i)
      OpNot:  res_limb_o = ~b_limb_i;
      OpAdd, OpSub, OpInc, OpAdc, OpSbb: begin
        res_limb_o = sum[W-1:0];
        chain_o    = sum[W];
      end
      OpAnd:  res_limb_o = a_limb_i & b_limb_i;
      OpOr:   res_limb_o = a_limb_i | b_limb_i;
      OpXor:  res_limb_o = a_limb_i ^ b_limb_i;
      OpShl: begin
        res_limb_o = {b_limb_i[W-2:0], chain_i};
        chain_o    = b_limb_i[W-1];
      end
      OpShr, OpAsr: begin
        res_limb_o = {chain_i, b_limb_i[W-1:1]};
        chain_o    = b_limb_i[0];
      end
      OpPass: res_limb_o = a_limb_i;
      default: begin
        res_limb_o = '0;
      end
    endcase
    if (is_msb_i && (op_i == OpAdd || op_i == OpSub || op_i == OpInc)) begin
      ovf_limb_o = (x[W-1] == y[W-1]) && (sum[W-1] != x[W-1]);
    end
  end

  assign limb_zero_o = (res_limb_o == '0);

endmodule

// File: rtl/mp_alu_seq.sv
// Multi-precision sequential ALU: one W-bit limb per cycle, valid/ready on both sides.
module mp_alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned WORDS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      op,
  input  logic [W*WORDS-1:0]   a,
  input  logic [W*WORDS-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W*WORDS-1:0]   result,
  output logic                 zr,
  output logic                 ng,
  output logic                 carry,
  output logic                 ovf
);

  localparam int unsigned N    = W * WORDS;
  localparam int unsigned CntW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WORDS - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  op_e             op_q, op_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [N-1:0]    result_q, result_d;
  logic            chain_q, chain_d;
  logic            zr_q, zr_d, ng_q, ng_d, carry_q, carry_d, ovf_q, ovf_d;
  logic            carry_reg_q, carry_reg_d;

  logic [CntW-1:0] limb_idx;
  logic [W-1:0]    a_limb, b_limb, res_limb;
  logic            is_msb, chain_out, limb_zero, ovf_limb;

  // Right shifts walk the limbs MSB-first so the shifted bit moves downwards.
  always_comb begin
    limb_idx = (op_q == OpShr || op_q == OpAsr) ? (LastCnt - cnt_q) : cnt_q;
    a_limb   = a_q[limb_idx*W +: W];
    b_limb   = b_q[limb_idx*W +: W];
    is_msb   = (limb_idx == LastCnt);
  end

  alu_limb #(
    .W (W)
  ) u_limb (
    .op_i        (op_q),
    .a_limb_i    (a_limb),
    .b_limb_i    (b_limb),
    .chain_i     (chain_q),
    .is_msb_i    (is_msb),
    .res_limb_o  (res_limb),
    .chain_o     (chain_out),
    .limb_zero_o (limb_zero),
    .ovf_limb_o  (ovf_limb)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    chain_d     = chain_q;
    zr_d        = zr_q;
    ng_d        = ng_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    carry_reg_d = carry_reg_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d     = op_e'(op);
          a_d      = a;
          b_d      = b;
          cnt_d    = '0;
          chain_d  = chain_init(op_e'(op), b[N-1], carry_reg_q);
          result_d = '0;
          zr_d     = 1'b1;
          ng_d     = 1'b0;
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          state_d  = StRun;
        end
      end
      StRun: begin
        result_d[limb_idx*W +: W] = res_limb;
        chain_d = chain_out;
        zr_d    = zr_q & limb_zero;
        if (is_msb) begin
          ng_d  = res_limb[W-1];
          ovf_d = ovf_limb;
        end
        if (cnt_q == LastCnt) begin
          carry_d = carry_from_chain(op_q, chain_out);
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          carry_reg_d = carry_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= OpNot;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      chain_q     <= 1'b0;
      zr_q        <= 1'b0;
      ng_q        <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      carry_reg_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      chain_q     <= chain_d;
      zr_q        <= zr_d;
      ng_q        <= ng_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      carry_reg_q <= carry_reg_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

endmodule
